// File: rtl/if_id_buffer.sv
// Fetch-to-decode FWFT buffer holding {pc, instruction} pairs with a valid/ready drain and flush.
// Optional IF_ID_PREDECODE_EN adds per-entry branch/jump flags derived at push time.
module if_id_buffer #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PC_W    = 5,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                       clk,
  input  logic                       counterRst,
  input  logic                       inValid,
  input  logic [PC_W-1:0]            inPc,
  input  logic [INSTR_W-1:0]         inInstr,
  output logic                       inReady,
  input  logic                       flush,
  output logic                       outValid,
  output logic [PC_W-1:0]            outPc,
  output logic [INSTR_W-1:0]         outInstr,
  input  logic                       outReady,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef IF_ID_PREDECODE_EN
  ,
  output logic                       outIsBranch,
  output logic                       outIsJump
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [PC_W-1:0]    pcMem    [DEPTH];
  logic [INSTR_W-1:0] instrMem [DEPTH];
  logic               push;
  logic               pop;

  // Handshake decisions come only from registered occupancy: no push-through when full.
  always_comb begin
    inReady  = (count != CNT_W'(DEPTH));
    outValid = (count != '0);
    push     = inValid & inReady;
    pop      = outValid & outReady;
  end

  always_ff @(posedge clk or posedge counterRst) begin
    if (counterRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pcMem[wrPtr]    <= inPc;
      instrMem[wrPtr] <= inInstr;
    end
  end

  always_comb begin
    outPc    = '0;
    outInstr = '0;
    if (outValid) begin
      outPc    = pcMem[rdPtr];
      outInstr = instrMem[rdPtr];
    end
  end

`ifdef IF_ID_PREDECODE_EN
  logic brMem [DEPTH];
  logic jmMem [DEPTH];
  logic inIsBranch;
  logic inIsJump;

  always_comb begin
    inIsBranch = (inInstr[31:26] == 6'b000100) || (inInstr[31:26] == 6'b000101);
    inIsJump   = (inInstr[31:26] == 6'b000010) || (inInstr[31:26] == 6'b000011);
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      brMem[wrPtr] <= inIsBranch;
      jmMem[wrPtr] <= inIsJump;
    end
  end

  always_comb begin
    outIsBranch = 1'b0;
    outIsJump   = 1'b0;
    if (outValid) begin
      outIsBranch = brMem[rdPtr];
      outIsJump   = jmMem[rdPtr];
    end
  end
`endif

endmodule
